nand_test_sequencer: RTL and testbench
======================================

// Module: nand_test_sequencer
// PURPOSE
//   Self-checking stimulus controller for the 2-input NAND gate.
//   On start, it drives all four {A,B} vectors (00,01,10,11) onto the gate and waits a programmable settle time.
//   It samples the gate output, compares it with ~(A&B), and reports a pass/fail summary.
//   Sits between the lab top level (buttons/LEDs) and the gate under test.
// PARAMETERS
//   SETTLE_CYCLES  2  clock cycles held in SETTLE before sampling; 0 is legal (SETTLE skipped)
//   CNT_W          3  width of err_count; saturates at 2**CNT_W-1
// PORTS
//   clk        in   1      single clock; all state changes on rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin a test run; accepted only in IDLE
//   a_out      out  1      registered A drive to gate under test
//   b_out      out  1      registered B drive to gate under test
//   dut_y      in   1      gate-under-test output
//   busy       out  1      high in APPLY/SETTLE/CHECK
//   done       out  1      high for exactly one cycle (DONE state)
//   pass       out  1      1 = last run had zero mismatches; held until next accepted start
//   err_count  out  CNT_W  mismatches in last run, saturating
//   fail_vec   out  4      bit i set if vector i ({A,B}=i) mismatched
// BEHAVIOUR
//   Reset: state=IDLE, idx=0; a_out, b_out, busy, done, pass, err_count, fail_vec all 0.
//   - rst wins over every other input, including mid-run: next cycle is IDLE with all-zero outputs.
//   FSM: IDLE -> APPLY -> SETTLE (x SETTLE_CYCLES) -> CHECK -> {APPLY | DONE} -> IDLE.
//   IDLE:
//     - start=1 -> APPLY, idx=0; err_count, fail_vec, pass cleared on the same edge.
//     - a_out/b_out are 0.
//   APPLY: one cycle; {a_out,b_out}<=idx registered on entry and held through SETTLE and CHECK.
//   SETTLE:
//     - Settle timer counts SETTLE_CYCLES cycles, then -> CHECK.
//     - SETTLE_CYCLES=0: APPLY goes directly to CHECK.
//   CHECK: one cycle; dut_y is sampled on the edge leaving CHECK.
//     - dut_y != ~(a_out&b_out): fail_vec[idx]<=1 and err_count<=err_count+1, saturating at max.
//     - idx==3 -> DONE; otherwise idx<=idx+1 and -> APPLY.
//   DONE:
//     - done=1 for one cycle; pass<=(err_count==0 after the final CHECK); a_out/b_out<=0.
//     - -> IDLE unconditionally.
//   Timing: per-vector cost 2+SETTLE_CYCLES cycles.
//     - start accepted at edge k -> done high during cycle k + 4*(2+SETTLE_CYCLES) + 1.
//     - SETTLE_CYCLES=2 -> 17; SETTLE_CYCLES=0 -> 9.
//   Boundary conditions:
//     - start ignored while busy or in DONE; no queuing; start held high restarts from IDLE.
//     - err_count never wraps.
//     - dut_y is ignored outside CHECK.
//     - Results (pass, err_count, fail_vec) are stable from DONE until the next accepted start or rst.
// STRUCTURE
//   Package nand_seq_pkg:
//     - state enum {IDLE, APPLY, SETTLE, CHECK, DONE}
//     - NUM_VECTORS=4
//     - function nand_expect(a,b) = ~(a&b)
//   Sub-module nand_settle_timer: load/count-down settle counter; params SETTLE_CYCLES; ports clk, rst, load, expired.
//   Top level: FSM, 2-bit idx, result registers.
// TESTING (SETTLE_CYCLES=2 unless stated)
//   1. Ideal NAND model on dut_y; start pulse at cycle 0 -> done at cycle 17, pass=1, err_count=0, fail_vec=4'b0000.
//   2. dut_y stuck at 1 -> fail_vec=4'b1000, err_count=1, pass=0.
//   3. AND gate in place of NAND -> fail_vec=4'b1111, err_count=4, pass=0.
//   4. start re-pulsed at cycles 5 and 17 -> both ignored; single done at 17; a/b sequence 00,01,10,11 unchanged.
//   5. rst high at cycle 6 -> cycle 7: busy=0, a_out=b_out=0, err_count=0; new start -> normal run, pass=1.
//   6. SETTLE_CYCLES=0, CNT_W=2, AND gate -> done at cycle 9, err_count=3 (saturated), fail_vec=4'b1111.

Source files
------------

// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND gate test sequencer.
//   seq_state_e  : sequencer FSM states
//   NUM_VECTORS  : number of {A,B} input combinations exercised per run
//   nand_expect  : golden model of the gate under test
package nand_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } seq_state_e;

  localparam int NUM_VECTORS = 4;

  // Golden response of a 2-input NAND gate.
  function automatic logic nand_expect(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_settle_timer.sv
// Settle-time counter for the NAND test sequencer.
// Loaded while a new vector is being applied, then counts down once per
// cycle. The sequencer stays in its settle state until 'expired' is seen.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   load    : reload the counter with the settle length
//   expired : settle time has elapsed (counter at zero)
module nand_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  // The counter is loaded with SETTLE_CYCLES-1 so that 'expired' is seen
  // during the last settle cycle, giving exactly SETTLE_CYCLES cycles.
  localparam int TMR_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOAD_VAL = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TMR_W'(LOAD_VAL);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/nand_test_sequencer.sv
// Self-checking stimulus controller for a 2-input NAND gate.
// On start it drives {A,B} = 00, 01, 10, 11 onto the gate, waits a settle
// time for each vector, compares the gate output with ~(A&B) and reports a
// pass/fail summary that is held until the next accepted start.
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a run (only accepted when idle)
//   a_out/b_out: registered drives to the gate under test
//   dut_y      : gate-under-test output
//   busy       : run in progress
//   done       : one-cycle end-of-run strobe
//   pass       : last run had no mismatches
//   err_count  : mismatches in last run, saturating
//   fail_vec   : bit i set if vector {A,B}=i mismatched
module nand_test_sequencer
  import nand_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  seq_state_e             state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic                   a_q, a_d, b_q, b_d;
  logic                   pass_q, pass_d;
  logic [CNT_W-1:0]       err_q, err_d;
  logic [NUM_VECTORS-1:0] fail_q, fail_d;
  logic                   timer_load;
  logic                   timer_expired;
  logic                   mismatch;

  nand_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .expired (timer_expired)
  );

  // The settle timer is armed during APPLY so it is already counting on
  // the first SETTLE cycle.
  assign timer_load = (state_q == APPLY);
  assign mismatch   = (dut_y != nand_expect(a_q, b_q));

  // Next-state and result logic. The A/B drives are updated on the edge
  // that enters APPLY, so the new vector is stable for the whole
  // APPLY/SETTLE/CHECK window, and are cleared on the edge entering DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      APPLY: begin
        state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (timer_expired) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          fail_d[idx_q] = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
        end
        // pass reflects the count including this final check, so it is
        // already valid while done is high.
        if (idx_q == 2'(NUM_VECTORS - 1)) begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          state_d    = APPLY;
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset overrides any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_nand_test_sequencer.sv
// Testbench for nand_test_sequencer: one instance with the default settle
// time driven by a selectable gate model, and one with no settle time and
// a 2-bit error counter driven by an AND gate.
module tb_nand_test_sequencer;

  typedef struct {
    logic [1:0] mode;
    bit         repulse;
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [3:0] exp_fail;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start2;
  logic [1:0] gate_mode;

  logic       a_out, b_out, dut_y, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  logic       a_out2, b_out2, dut_y2, busy2, done2, pass2;
  logic [1:0] err_count2;
  logic [3:0] fail_vec2;

  int checks = 0;
  int errors = 0;

  nand_test_sequencer #(
    .SETTLE_CYCLES(2),
    .CNT_W        (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .dut_y     (dut_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  nand_test_sequencer #(
    .SETTLE_CYCLES(0),
    .CNT_W        (2)
  ) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .a_out     (a_out2),
    .b_out     (b_out2),
    .dut_y     (dut_y2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err_count2),
    .fail_vec  (fail_vec2)
  );

  // Gate models: 0 ideal NAND, 1 stuck-at-1, 2 AND gate, 3 stuck-at-0.
  function automatic logic gate_model(input logic [1:0] mode, input logic a, input logic b);
    case (mode)
      2'd0:    return ~(a & b);
      2'd1:    return 1'b1;
      2'd2:    return a & b;
      default: return 1'b0;
    endcase
  endfunction

  assign dut_y  = gate_model(gate_mode, a_out, b_out);
  assign dut_y2 = a_out2 & b_out2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Run one complete test on the main instance. Starts at a negedge with
  // start high during cycle 0; cycle n is the interval after edge n.
  task automatic applyStimulus(input vec_t v, input string tag);
    int         done_edge;
    int         done_cnt;
    int         busy_cnt;
    int         nseq;
    int         prev;
    logic [7:0] seq;
    logic       res_pass;
    logic [2:0] res_err;
    logic [3:0] res_fail;
    done_edge = -1;
    done_cnt  = 0;
    busy_cnt  = 0;
    nseq      = 0;
    prev      = -1;
    seq       = 8'h00;
    res_pass  = 1'bx;
    res_err   = 3'bxxx;
    res_fail  = 4'bxxxx;
    gate_mode = v.mode;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = v.repulse && (cyc == 5 || cyc == 17);
      if (busy) begin
        busy_cnt++;
        if (int'({a_out, b_out}) != prev) begin
          prev = int'({a_out, b_out});
          seq  = {seq[5:0], a_out, b_out};
          nseq++;
        end
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
        res_pass  = pass;
        res_err   = err_count;
        res_fail  = fail_vec;
      end
    end
    checkOutput({tag, " done_cycle"}, done_edge, 17);
    checkOutput({tag, " done_count"}, done_cnt, 1);
    checkOutput({tag, " busy_cycles"}, busy_cnt, 16);
    checkOutput({tag, " ab_seq_len"}, nseq, 4);
    checkOutput({tag, " ab_seq"}, seq, 8'b00_01_10_11);
    checkOutput({tag, " pass@done"}, res_pass, v.exp_pass);
    checkOutput({tag, " err@done"}, res_err, v.exp_err);
    checkOutput({tag, " fail@done"}, res_fail, v.exp_fail);
    checkOutput({tag, " pass_held"}, pass, v.exp_pass);
    checkOutput({tag, " err_held"}, err_count, v.exp_err);
    checkOutput({tag, " fail_held"}, fail_vec, v.exp_fail);
    checkOutput({tag, " ab_idle"}, {a_out, b_out}, 2'b00);
    checkOutput({tag, " busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    vec_t vecs[5];
    int   done_edge2;
    int   busy_cnt2;

    vecs[0] = '{mode: 2'd0, repulse: 1'b0, exp_pass: 1'b1, exp_err: 3'd0, exp_fail: 4'b0000};
    vecs[1] = '{mode: 2'd1, repulse: 1'b0, exp_pass: 1'b0, exp_err: 3'd1, exp_fail: 4'b1000};
    vecs[2] = '{mode: 2'd2, repulse: 1'b0, exp_pass: 1'b0, exp_err: 3'd4, exp_fail: 4'b1111};
    vecs[3] = '{mode: 2'd0, repulse: 1'b1, exp_pass: 1'b1, exp_err: 3'd0, exp_fail: 4'b0000};
    vecs[4] = '{mode: 2'd3, repulse: 1'b0, exp_pass: 1'b0, exp_err: 3'd3, exp_fail: 4'b0111};

    rst       = 1'b1;
    start     = 1'b0;
    start2    = 1'b0;
    gate_mode = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset ab", {a_out, b_out}, 2'b00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset pass", pass, 1'b0);
    checkOutput("reset err", err_count, 3'd0);
    checkOutput("reset fail", fail_vec, 4'b0000);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset mid-run with an AND gate: one mismatch is already counted
    // before rst, and everything must be clear the cycle after.
    $display("[TB] mid-run reset");
    gate_mode = 2'd2;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 6) begin
        checkOutput("pre-reset err", err_count, 3'd1);
        checkOutput("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
      end
    end
    rst = 1'b0;
    checkOutput("post-reset busy", busy, 1'b0);
    checkOutput("post-reset ab", {a_out, b_out}, 2'b00);
    checkOutput("post-reset err", err_count, 3'd0);
    checkOutput("post-reset fail", fail_vec, 4'b0000);
    checkOutput("post-reset done", done, 1'b0);
    @(negedge clk);
    applyStimulus(vecs[0], "after_reset");
    @(negedge clk);

    // Zero settle time, 2-bit saturating counter, AND gate.
    $display("[TB] zero settle instance");
    done_edge2 = -1;
    busy_cnt2  = 0;
    start2     = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) busy_cnt2++;
      if (done2 && done_edge2 < 0) begin
        done_edge2 = cyc;
        checkOutput("fast err@done", err_count2, 2'd3);
        checkOutput("fast fail@done", fail_vec2, 4'b1111);
        checkOutput("fast pass@done", pass2, 1'b0);
      end
    end
    checkOutput("fast done_cycle", done_edge2, 9);
    checkOutput("fast busy_cycles", busy_cnt2, 8);
    checkOutput("fast err_held", err_count2, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
